// File: rtl/ascon_reg_pkg.sv
// rtl/ascon_reg_pkg.sv - shared types, register map and FSM states for the ASCON register master
package ascon_reg_pkg;

  localparam int          ASCON_NUM_STATE_WORDS = 10;
  localparam logic [31:0] ASCON_STATUS_OFFSET   = 32'h28;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_STATE,
    S_WR_START,
    S_WAIT_DONE,
    S_WR_CLEAR,
    S_RD_STATE,
    S_RESP
  } master_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } ascon_reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } ascon_reg_rsp_t;

  function automatic logic [31:0] ASCON_STATE_OFFSET(input logic [3:0] w);
    return {26'd0, w, 2'b00};
  endfunction

  // Even words carry the low half of a lane, odd words the high half.
  function automatic logic [31:0] ascon_state_word(input logic [4:0][63:0] st,
                                                   input logic [3:0]       w);
    return w[0] ? st[w[3:1]][63:32] : st[w[3:1]][31:0];
  endfunction

endpackage

// File: rtl/ascon_reg_xfer.sv
// rtl/ascon_reg_xfer.sv - single register-bus transfer engine; holds the request until ready
module ascon_reg_xfer #(
  parameter type reg_req_t = ascon_reg_pkg::ascon_reg_req_t,
  parameter type reg_rsp_t = ascon_reg_pkg::ascon_reg_rsp_t
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_write,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_error,
  output reg_req_t    o_reg_req,
  input  reg_rsp_t    i_reg_rsp
);

  logic        r_valid;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  assign o_done  = r_valid & i_reg_rsp.ready;
  assign o_rdata = i_reg_rsp.rdata;
  assign o_error = o_done & i_reg_rsp.error;

  // A start in the completing cycle loads the next request for the following cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
    end else if (i_start) begin
      r_valid <= 1'b1;
      r_write <= i_write;
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
    end else if (o_done) begin
      r_valid <= 1'b0;
    end
  end

  always_comb begin
    o_reg_req       = '0;
    o_reg_req.addr  = r_addr;
    o_reg_req.write = r_write;
    o_reg_req.wdata = r_wdata;
    o_reg_req.wstrb = 4'hF;
    o_reg_req.valid = r_valid;
  end

endmodule

// File: rtl/ascon_reg_master.sv
// rtl/ascon_reg_master.sv - sequences one ASCON permutation job over the accelerator register bus
module ascon_reg_master
  import ascon_reg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter type         reg_req_t      = ascon_reg_req_t,
  parameter type         reg_rsp_t      = ascon_reg_rsp_t
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [4:0][63:0] cmd_state_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [4:0][63:0] rsp_state_o,
  output logic             rsp_error_o,
  output logic             busy_o,
  input  logic             finished_i,
  output reg_req_t         reg_req_o,
  input  reg_rsp_t         reg_rsp_i
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  master_state_e    r_state, w_next_state;
  logic [3:0]       r_widx, w_next_widx;
  logic [TW-1:0]    r_tmo;
  logic             r_done_flag;
  logic             r_err;
  logic             r_cmd_ready;
  logic [4:0][63:0] r_job;
  logic [4:0][63:0] r_rsp_state;

  logic        w_accept;
  logic        w_done_seen;
  logic        w_last;
  logic        w_timeout;
  logic [3:0]  w_widx_inc;
  logic        w_issue;
  logic        w_issue_wr;
  logic [31:0] w_issue_addr;
  logic [31:0] w_issue_data;
  logic        w_xfer_done;
  logic        w_xfer_err;
  logic [31:0] w_xfer_rdata;

  assign w_accept    = cmd_valid_i & r_cmd_ready;
  assign w_done_seen = r_done_flag | finished_i;
  assign w_last      = (r_widx == 4'(ASCON_NUM_STATE_WORDS - 1));
  assign w_widx_inc  = r_widx + 4'd1;

  assign cmd_ready_o = r_cmd_ready;
  assign rsp_valid_o = (r_state == S_RESP);
  assign rsp_state_o = r_rsp_state;
  assign rsp_error_o = r_err;
  assign busy_o      = (r_state != S_IDLE);

  ascon_reg_xfer #(
    .reg_req_t (reg_req_t),
    .reg_rsp_t (reg_rsp_t)
  ) u_xfer (
    .i_clk     (clk_i),
    .i_rst_n   (rst_n_i),
    .i_start   (w_issue),
    .i_write   (w_issue_wr),
    .i_addr    (w_issue_addr),
    .i_wdata   (w_issue_data),
    .o_done    (w_xfer_done),
    .o_rdata   (w_xfer_rdata),
    .o_error   (w_xfer_err),
    .o_reg_req (reg_req_o),
    .i_reg_rsp (reg_rsp_i)
  );

  // Default issue is the STATUS=0 clear write; states override for other transfers.
  always_comb begin
    w_next_state = r_state;
    w_next_widx  = r_widx;
    w_issue      = 1'b0;
    w_issue_wr   = 1'b1;
    w_issue_addr = BASE_ADDR + ASCON_STATUS_OFFSET;
    w_issue_data = 32'h0;
    w_timeout    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_issue      = 1'b1;
          w_issue_addr = BASE_ADDR + ASCON_STATE_OFFSET(4'd0);
          w_issue_data = ascon_state_word(cmd_state_i, 4'd0);
          w_next_widx  = 4'd0;
          w_next_state = S_WR_STATE;
        end
      end
      S_WR_STATE: begin
        if (w_xfer_done) begin
          w_issue = 1'b1;
          if (w_xfer_err) begin
            w_next_state = S_WR_CLEAR;
          end else if (w_last) begin
            w_issue_data = 32'h1;
            w_next_state = S_WR_START;
          end else begin
            w_next_widx  = w_widx_inc;
            w_issue_addr = BASE_ADDR + ASCON_STATE_OFFSET(w_widx_inc);
            w_issue_data = ascon_state_word(r_job, w_widx_inc);
          end
        end
      end
      S_WR_START: begin
        if (w_xfer_done) begin
          if (w_xfer_err || w_done_seen) begin
            w_issue      = 1'b1;
            w_next_state = S_WR_CLEAR;
          end else begin
            w_next_state = S_WAIT_DONE;
          end
        end
      end
      S_WAIT_DONE: begin
        if (w_done_seen) begin
          w_issue      = 1'b1;
          w_next_state = S_WR_CLEAR;
        end else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
          w_issue      = 1'b1;
          w_timeout    = 1'b1;
          w_next_state = S_WR_CLEAR;
        end
      end
      S_WR_CLEAR: begin
        if (w_xfer_done) begin
          if (r_err || w_xfer_err) begin
            w_next_state = S_RESP;
          end else begin
            w_issue      = 1'b1;
            w_issue_wr   = 1'b0;
            w_issue_addr = BASE_ADDR + ASCON_STATE_OFFSET(4'd0);
            w_next_widx  = 4'd0;
            w_next_state = S_RD_STATE;
          end
        end
      end
      S_RD_STATE: begin
        if (w_xfer_done) begin
          if (w_xfer_err) begin
            w_issue      = 1'b1;
            w_next_state = S_WR_CLEAR;
          end else if (w_last) begin
            w_next_state = S_RESP;
          end else begin
            w_issue      = 1'b1;
            w_issue_wr   = 1'b0;
            w_issue_addr = BASE_ADDR + ASCON_STATE_OFFSET(w_widx_inc);
            w_next_widx  = w_widx_inc;
          end
        end
      end
      S_RESP: begin
        if (rsp_ready_i) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= S_IDLE;
      r_widx      <= 4'd0;
      r_tmo       <= '0;
      r_done_flag <= 1'b0;
      r_err       <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_job       <= '0;
      r_rsp_state <= '0;
    end else begin
      r_state     <= w_next_state;
      r_widx      <= w_next_widx;
      r_cmd_ready <= (w_next_state == S_IDLE);
      if (r_state == S_WR_START) begin
        r_tmo <= '0;
      end else if (r_state == S_WAIT_DONE) begin
        r_tmo <= r_tmo + TW'(1);
      end
      if (w_accept) begin
        r_job       <= cmd_state_i;
        r_err       <= 1'b0;
        r_done_flag <= 1'b0;
        r_rsp_state <= '0;
      end else begin
        // Completion pulses before the start write cannot belong to this job.
        if (finished_i && !(r_state inside {S_IDLE, S_WR_STATE})) r_done_flag <= 1'b1;
        if (w_xfer_err || w_timeout) r_err <= 1'b1;
        if (r_state == S_RD_STATE && w_xfer_done && !w_xfer_err) begin
          r_rsp_state[r_widx[3:1]][{r_widx[0], 5'd0} +: 32] <= w_xfer_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_ascon_reg_master.sv
// tb/tb_ascon_reg_master.sv - directed self-checking bench for ascon_reg_master
module tb_ascon_reg_master;
  import ascon_reg_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [4:0][63:0] cmd_state = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [4:0][63:0] rsp_state;
  logic             rsp_error;
  logic             busy;
  logic             finished = 1'b0;
  ascon_reg_req_t   reg_req;
  ascon_reg_rsp_t   reg_rsp;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc = 0;
  int base = 0;
  logic [4:0][63:0] got_state;
  logic             got_err;

  // Slave model: ten STATE words plus STATUS; STATUS=1 applies a fake permutation.
  logic [31:0] mem [0:15];
  int          wait_cfg = 0;
  int          wcnt = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic [31:0] log_addr  [0:255];
  logic [31:0] log_wdata [0:255];
  logic        log_wr    [0:255];
  int          log_cyc   [0:255];
  int          n_log = 0;
  int          stab_err = 0;
  int          strb_err = 0;
  logic        hold_pend = 1'b0;
  logic [64:0] hold_req = '0;

  ascon_reg_master #(
    .BASE_ADDR      (32'h0),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_state_i (cmd_state),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_state_o (rsp_state),
    .rsp_error_o (rsp_error),
    .busy_o      (busy),
    .finished_i  (finished),
    .reg_req_o   (reg_req),
    .reg_rsp_i   (reg_rsp)
  );

  always #5 clk = ~clk;

  always_comb begin
    reg_rsp       = '0;
    reg_rsp.ready = reg_req.valid && (wcnt >= wait_cfg);
    reg_rsp.rdata = mem[reg_req.addr[5:2]];
    reg_rsp.error = reg_rsp.ready && reg_req.write && (reg_req.addr == err_addr);
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reg_req.valid && reg_rsp.ready) wcnt <= 0;
    else if (reg_req.valid)             wcnt <= wcnt + 1;
    else                                wcnt <= 0;
  end

  always @(negedge clk) begin
    if (reg_req.valid && hold_pend &&
        ({reg_req.addr, reg_req.write, reg_req.wdata} !== hold_req)) stab_err++;
    if (reg_req.valid && reg_rsp.ready) begin
      if (n_log < 256) begin
        log_addr[n_log]  = reg_req.addr;
        log_wdata[n_log] = reg_req.wdata;
        log_wr[n_log]    = reg_req.write;
        log_cyc[n_log]   = cyc;
      end
      n_log++;
      if (reg_req.wstrb !== 4'hF) strb_err++;
      if (reg_req.write) begin
        mem[reg_req.addr[5:2]] = reg_req.wdata;
        if (reg_req.addr == 32'h28 && reg_req.wdata == 32'h1) begin
          for (int i = 0; i < 10; i++) mem[i] = mem[i] ^ 32'hA5A5_0000 ^ 32'(i);
        end
      end
      hold_pend = 1'b0;
    end else begin
      hold_pend = reg_req.valid;
      hold_req  = {reg_req.addr, reg_req.write, reg_req.wdata};
    end
  end

  function automatic logic [31:0] word_of(input logic [4:0][63:0] st, input int w);
    logic [63:0] x;
    x = st[w / 2];
    return (w % 2 == 1) ? x[63:32] : x[31:0];
  endfunction

  function automatic logic [4:0][63:0] model(input logic [4:0][63:0] st);
    logic [4:0][63:0] r;
    logic [31:0]      v;
    r = '0;
    for (int w = 0; w < 10; w++) begin
      v = word_of(st, w) ^ 32'hA5A5_0000 ^ 32'(w);
      if (w % 2 == 1) r[w / 2][63:32] = v;
      else            r[w / 2][31:0]  = v;
    end
    return r;
  endfunction

  function automatic logic [96:0] ent(input int i);
    return {log_addr[i], log_wr[i], log_wdata[i], 32'(log_cyc[i])};
  endfunction

  task automatic start_job(input logic [4:0][63:0] st);
    int g;
    g = 0;
    @(negedge clk);
    while (!cmd_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready_before_job: got %b want 1", cmd_ready);
    end
    cmd_state = st;
    cmd_valid = 1'b1;
    acc       = cyc;
    base      = n_log;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_at(input int c);
    int g;
    g = 0;
    while (cyc < c && g < 500) begin
      @(negedge clk);
      g++;
    end
    finished = 1'b1;
    @(negedge clk);
    finished = 1'b0;
  endtask

  task automatic wait_rsp(output int rc);
    int g;
    g  = 0;
    rc = -1;
    while (!rsp_valid && g < 300) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (!rsp_valid) begin
      errors++;
      $display("FAIL rsp_valid_timeout: got 0 want 1 within 300 cycles");
    end else begin
      rc        = cyc - acc;
      got_state = rsp_state;
      got_err   = rsp_error;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({reg_req.valid, cmd_ready, rsp_valid, rsp_error, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000",
               {reg_req.valid, cmd_ready, rsp_valid, rsp_error, busy});
    end
    checks++;
    if (rsp_state !== '0) begin
      errors++;
      $display("FAIL reset_rsp_state: got %h want 0", rsp_state);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got ready=%b busy=%b want ready=1 busy=0", cmd_ready, busy);
    end
  endtask

  task automatic test_zero_wait;
    logic [4:0][63:0] st;
    logic [96:0]      e;
    int               rc;
    st = {5{64'hFFFF_FFFF_FFFF_FFFF}};
    wait_cfg = 0;
    start_job(st);
    pulse_at(acc + 20);
    wait_rsp(rc);
    checks++;
    if (n_log - base !== 22) begin
      errors++;
      $display("FAIL zw_count: got %0d want 22", n_log - base);
    end
    for (int i = 0; i < 10; i++) begin
      e = {32'(4 * i), 1'b1, 32'hFFFF_FFFF, 32'(acc + 1 + i)};
      checks++;
      if (ent(base + i) !== e) begin
        errors++;
        $display("FAIL zw_write%0d: got %h want %h", i, ent(base + i), e);
      end
    end
    e = {32'h28, 1'b1, 32'h1, 32'(acc + 11)};
    checks++;
    if (ent(base + 10) !== e) begin
      errors++;
      $display("FAIL zw_start: got %h want %h", ent(base + 10), e);
    end
    e = {32'h28, 1'b1, 32'h0, 32'(acc + 21)};
    checks++;
    if (ent(base + 11) !== e) begin
      errors++;
      $display("FAIL zw_clear: got %h want %h", ent(base + 11), e);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({log_addr[base + 12 + i], log_wr[base + 12 + i], 32'(log_cyc[base + 12 + i])} !==
          {32'(4 * i), 1'b0, 32'(acc + 22 + i)}) begin
        errors++;
        $display("FAIL zw_read%0d: got addr=%h wr=%b cyc=%0d want addr=%h wr=0 cyc=%0d", i,
                 log_addr[base + 12 + i], log_wr[base + 12 + i], log_cyc[base + 12 + i] - acc,
                 4 * i, 22 + i);
      end
    end
    checks++;
    if (rc !== 32) begin
      errors++;
      $display("FAIL zw_rsp_cycle: got %0d want 32", rc);
    end
    checks++;
    if (got_err !== 1'b0 || got_state !== model(st)) begin
      errors++;
      $display("FAIL zw_result: got err=%b state=%h want err=0 state=%h", got_err, got_state, model(st));
    end
  endtask

  task automatic test_wait_states;
    logic [4:0][63:0] st;
    int               rc;
    for (int i = 0; i < 5; i++) st[i] = {32'hC0DE_0000 | 32'(2 * i + 1), 32'hC0DE_0000 | 32'(2 * i)};
    wait_cfg = 3;
    start_job(st);
    pulse_at(acc + 60);
    wait_rsp(rc);
    wait_cfg = 0;
    checks++;
    if (stab_err !== 0 || strb_err !== 0) begin
      errors++;
      $display("FAIL ws_hold: got stab=%0d strb=%0d want 0 0", stab_err, strb_err);
    end
    checks++;
    if (n_log - base !== 22) begin
      errors++;
      $display("FAIL ws_count: got %0d want 22", n_log - base);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (ent(base + i) !== {32'(4 * i), 1'b1, 32'hC0DE_0000 | 32'(i), 32'(acc + 4 * (i + 1))}) begin
        errors++;
        $display("FAIL ws_write%0d: got %h want addr=%h data=%h cyc=%0d", i, ent(base + i),
                 4 * i, 32'hC0DE_0000 | 32'(i), 4 * (i + 1));
      end
    end
    checks++;
    if ({log_addr[base + 10], log_wdata[base + 10], log_addr[base + 11], log_wdata[base + 11]} !==
        {32'h28, 32'h1, 32'h28, 32'h0}) begin
      errors++;
      $display("FAIL ws_status_order: got %h/%h %h/%h want 28/1 28/0", log_addr[base + 10],
               log_wdata[base + 10], log_addr[base + 11], log_wdata[base + 11]);
    end
    checks++;
    if (got_err !== 1'b0 || got_state !== model(st)) begin
      errors++;
      $display("FAIL ws_result: got err=%b state=%h want err=0 state=%h", got_err, got_state, model(st));
    end
  endtask

  task automatic test_finish_same_cycle;
    logic [4:0][63:0] st;
    int               rc;
    st = {64'h0011_2233_4455_6677, 64'h8899_AABB_CCDD_EEFF, 64'hDEAD_BEEF_0BAD_F00D,
          64'h1357_9BDF_2468_ACE0, 64'hFEDC_BA98_7654_3210};
    start_job(st);
    pulse_at(acc + 11);
    wait_rsp(rc);
    checks++;
    if (ent(base + 11) !== {32'h28, 1'b1, 32'h0, 32'(acc + 12)}) begin
      errors++;
      $display("FAIL sc_clear: got %h want addr=28 data=0 cyc=12", ent(base + 11));
    end
    checks++;
    if (rc !== 23) begin
      errors++;
      $display("FAIL sc_rsp_cycle: got %0d want 23", rc);
    end
    checks++;
    if (got_err !== 1'b0 || got_state !== model(st)) begin
      errors++;
      $display("FAIL sc_result: got err=%b state=%h want err=0 state=%h", got_err, got_state, model(st));
    end
  endtask

  task automatic test_timeout;
    logic [4:0][63:0] st;
    int               rc;
    st = {5{64'h5A5A_5A5A_A5A5_A5A5}};
    start_job(st);
    pulse_at(acc + 5);
    wait_rsp(rc);
    checks++;
    if (n_log - base !== 12) begin
      errors++;
      $display("FAIL to_count: got %0d want 12", n_log - base);
    end
    checks++;
    if (ent(base + 11) !== {32'h28, 1'b1, 32'h0, 32'(acc + 28)}) begin
      errors++;
      $display("FAIL to_clear: got %h want addr=28 data=0 cyc=28", ent(base + 11));
    end
    checks++;
    if (rc !== 29) begin
      errors++;
      $display("FAIL to_rsp_cycle: got %0d want 29", rc);
    end
    checks++;
    if (got_err !== 1'b1 || got_state !== '0) begin
      errors++;
      $display("FAIL to_result: got err=%b state=%h want err=1 state=0", got_err, got_state);
    end
  endtask

  task automatic test_bus_error;
    logic [4:0][63:0] st;
    int               rc;
    st = {5{64'h0F0F_0F0F_F0F0_F0F0}};
    err_addr = 32'h0C;
    start_job(st);
    wait_rsp(rc);
    err_addr = 32'hFFFF_FFFF;
    checks++;
    if (n_log - base !== 5) begin
      errors++;
      $display("FAIL be_count: got %0d want 5", n_log - base);
    end
    checks++;
    if (ent(base + 4) !== {32'h28, 1'b1, 32'h0, 32'(acc + 5)}) begin
      errors++;
      $display("FAIL be_clear: got %h want addr=28 data=0 cyc=5", ent(base + 4));
    end
    checks++;
    if (rc !== 6 || got_err !== 1'b1 || got_state !== '0) begin
      errors++;
      $display("FAIL be_result: got cyc=%0d err=%b state=%h want cyc=6 err=1 state=0",
               rc, got_err, got_state);
    end
  endtask

  task automatic test_reset_mid_job;
    logic [4:0][63:0] st;
    int               rc;
    int               g;
    int               nl;
    st = {5{64'h1234_5678_9ABC_DEF0}};
    start_job(st);
    pulse_at(acc + 20);
    g = 0;
    while (cyc < acc + 27 && g < 100) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if ({reg_req.valid, reg_req.write, reg_req.addr} !== {1'b1, 1'b0, 32'h14}) begin
      errors++;
      $display("FAIL rm_read5: got v=%b w=%b addr=%h want v=1 w=0 addr=14",
               reg_req.valid, reg_req.write, reg_req.addr);
    end
    rst_n = 1'b0;
    #1;
    nl = n_log;
    checks++;
    if ({reg_req.valid, cmd_ready, rsp_valid, rsp_error, busy} !== 5'b0 || rsp_state !== '0) begin
      errors++;
      $display("FAIL rm_outputs: got %b state=%h want 00000 state=0",
               {reg_req.valid, cmd_ready, rsp_valid, rsp_error, busy}, rsp_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    st = {64'hAAAA_0000_BBBB_1111, 64'hCCCC_2222_DDDD_3333, 64'hEEEE_4444_FFFF_5555,
          64'h0000_6666_1111_7777, 64'h2222_8888_3333_9999};
    start_job(st);
    checks++;
    if (base !== nl) begin
      errors++;
      $display("FAIL rm_no_clear: got %0d transfers after reset want 0", base - nl);
    end
    pulse_at(acc + 20);
    wait_rsp(rc);
    checks++;
    if (rc !== 32 || n_log - base !== 22) begin
      errors++;
      $display("FAIL rm_rejob_timing: got cyc=%0d n=%0d want cyc=32 n=22", rc, n_log - base);
    end
    checks++;
    if (got_err !== 1'b0 || got_state !== model(st)) begin
      errors++;
      $display("FAIL rm_rejob_result: got err=%b state=%h want err=0 state=%h",
               got_err, got_state, model(st));
    end
  endtask

  initial begin
    test_reset;
    test_zero_wait;
    test_wait_states;
    test_finish_same_cycle;
    test_timeout;
    test_bus_error;
    test_reset_mid_job;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1);
  end

endmodule
